// File: rtl/inst_encoder.sv
// RV32I instruction encoder: assembles a word from format/fields/immediate, range-checks the
// immediate and buffers {err, inst} in a small FIFO. Optional error counter: INST_ENCODER_ERR_CNT_EN.
module inst_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_format,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_immediate,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic        o_err
`ifdef INST_ENCODER_ERR_CNT_EN
  ,
  output logic [15:0] o_err_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  logic [31:0] imm;
  logic        isOneHot;
  logic        sameI;
  logic        sameB;
  logic        sameJ;
  logic [31:0] encInst;
  logic        encErr;

  assign imm      = i_immediate;
  assign isOneHot = (i_format != 6'd0) && ((i_format & (i_format - 6'd1)) == 6'd0);
  // A field fits when every bit above its sign bit is a copy of that sign bit.
  assign sameI    = (&imm[31:11]) || (~|imm[31:11]);
  assign sameB    = (&imm[31:12]) || (~|imm[31:12]);
  assign sameJ    = (&imm[31:20]) || (~|imm[31:20]);

  always_comb begin
    encInst = 32'h00000013;
    encErr  = 1'b1;
    if (isOneHot) begin
      case (1'b1)
        i_format[0]: begin
          encInst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
          encErr  = 1'b0;
        end
        i_format[1]: begin
          encInst = {imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
          encErr  = !sameI;
        end
        i_format[2]: begin
          encInst = {imm[11:5], i_rs2, i_rs1, i_funct3, imm[4:0], i_opcode};
          encErr  = !sameI;
        end
        i_format[3]: begin
          encInst = {imm[12], imm[10:5], i_rs2, i_rs1, i_funct3, imm[4:1], imm[11], i_opcode};
          encErr  = !sameB || imm[0];
        end
        i_format[4]: begin
          encInst = {imm[31:12], i_rd, i_opcode};
          encErr  = (imm[11:0] != 12'd0);
        end
        default: begin
          encInst = {imm[20], imm[10:1], imm[11], imm[19:12], i_rd, i_opcode};
          encErr  = !sameJ || imm[0];
        end
      endcase
    end
  end

  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;
  logic [32:0]   head;

  assign o_ready = (count_q != FULL_COUNT);
  assign o_valid = (count_q != '0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;
  // Outputs read as zero while empty so stale entries never leak out.
  assign head    = o_valid ? mem_q[rdPtr_q] : 33'd0;
  assign o_err   = head[32];
  assign o_inst  = head[31:0];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wrPtr_q] <= {encErr, encInst};
  end

`ifdef INST_ENCODER_ERR_CNT_EN
  logic [15:0] errCnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      errCnt_q <= 16'd0;
    end else if (push && encErr && (errCnt_q != 16'hFFFF)) begin
      errCnt_q <= errCnt_q + 16'd1;
    end
  end

  assign o_err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: vector table for encoding/range checks, plus
// hand-written backpressure, streaming and mid-stream reset sequences.
module tb_inst_encoder;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [5:0]  i_format;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_immediate;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic        o_err;
`ifdef INST_ENCODER_ERR_CNT_EN
  logic [15:0] o_err_cnt;
`endif

  inst_encoder #(.FIFO_DEPTH(2)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_format    (i_format),
    .i_opcode    (i_opcode),
    .i_rd        (i_rd),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_funct3    (i_funct3),
    .i_funct7    (i_funct7),
    .i_immediate (i_immediate),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_inst      (o_inst),
    .o_err       (o_err)
`ifdef INST_ENCODER_ERR_CNT_EN
    ,
    .o_err_cnt   (o_err_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [5:0]  format;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] expInst;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic [5:0] fmt, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] expInst, input logic expErr);
    vec_t v;
    v.name = name; v.format = fmt; v.opcode = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.funct3 = f3; v.funct7 = f7; v.imm = imm; v.expInst = expInst; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    i_format    = v.format;
    i_opcode    = v.opcode;
    i_rd        = v.rd;
    i_rs1       = v.rs1;
    i_rs2       = v.rs2;
    i_funct3    = v.funct3;
    i_funct7    = v.funct7;
    i_immediate = v.imm;
  endtask

  // addi x1, x0, k encoding for small positive k
  function automatic logic [31:0] iWord(input logic [11:0] k);
    return {k, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  task automatic driveAddi(input logic [11:0] k);
    i_format    = 6'b000010;
    i_opcode    = 7'h13;
    i_rd        = 5'd1;
    i_rs1       = 5'd0;
    i_rs2       = 5'd0;
    i_funct3    = 3'd0;
    i_funct7    = 7'd0;
    i_immediate = {20'd0, k};
  endtask

  initial begin
    int          expErrCount;
    int          accepted;
    logic [11:0] seq;
    logic [31:0] expQ[$];

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_format = '0; i_opcode = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
    i_funct3 = '0; i_funct7 = '0; i_immediate = '0;

    addVec("I_addi",   6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    addVec("S_sw",     6'b000100, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h00000008, 32'h0020A423, 1'b0);
    addVec("U_lui",    6'b010000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0);
    addVec("B_beq",    6'b001000, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    addVec("J_jal",    6'b100000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h001000EF, 1'b0);
    addVec("R_add",    6'b000001, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0);
    addVec("R_sub",    6'b000001, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 32'h402081B3, 1'b0);
    addVec("I_min",    6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0);
    addVec("I_max",    6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000007FF, 32'h7FF00093, 1'b0);
    addVec("J_min",    6'b100000, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b0);
    addVec("B_odd",    6'b001000, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000003, 32'h00000163, 1'b1);
    addVec("I_over",   6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1);
    addVec("U_low",    6'b010000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001001, 32'h000012B7, 1'b1);
    addVec("fmt_two",  6'b000011, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 32'h00000013, 1'b1);
    addVec("fmt_zero", 6'b000000, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 32'h00000013, 1'b1);
    addVec("J_odd",    6'b100000, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001, 32'h0000006F, 1'b1);
    addVec("B_over",   6'b001000, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 32'h80000063, 1'b1);

    #1;
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_ready", 32'(o_ready), 32'd1);
    checkOutput("rst_inst",  o_inst,       32'd0);
    checkOutput("rst_err",   32'(o_err),   32'd0);
`ifdef INST_ENCODER_ERR_CNT_EN
    checkOutput("rst_errcnt", 32'(o_err_cnt), 32'd0);
`endif
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    expErrCount = 0;
    foreach (vecs[n]) begin
      applyStimulus(vecs[n]);
      if (vecs[n].expErr) expErrCount++;
      i_valid = 1'b1;
      i_ready = 1'b0;
      checkOutput({vecs[n].name, "_ready"}, 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_valid = 1'b0;
      checkOutput({vecs[n].name, "_valid"}, 32'(o_valid), 32'd1);
      checkOutput({vecs[n].name, "_inst"},  o_inst, vecs[n].expInst);
      checkOutput({vecs[n].name, "_err"},   32'(o_err), 32'(vecs[n].expErr));
      i_ready = 1'b1;
      @(negedge i_clk);
      checkOutput({vecs[n].name, "_popped"}, 32'(o_valid), 32'd0);
      i_ready = 1'b0;
    end
`ifdef INST_ENCODER_ERR_CNT_EN
    checkOutput("errcnt_table", 32'(o_err_cnt), 32'(expErrCount));
`endif

    // Backpressure: downstream stalled, requests offered every cycle.
    accepted = 0;
    seq = 12'h010;
    i_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      driveAddi(seq);
      i_valid = 1'b1;
      if (o_ready) begin
        expQ.push_back(iWord(seq));
        accepted++;
        seq = seq + 12'd1;
      end
      @(negedge i_clk);
    end
    checkOutput("bp_accepts", 32'(accepted), 32'd2);
    checkOutput("bp_full_ready", 32'(o_ready), 32'd0);
    checkOutput("bp_head_stable", o_inst, iWord(12'h010));
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("bp_drain_valid", 32'(o_valid), 32'd1);
      checkOutput("bp_drain_inst", o_inst, expQ[k]);
      @(negedge i_clk);
    end
    checkOutput("bp_empty", 32'(o_valid), 32'd0);

    // Streaming: push and pop together give one word per cycle.
    seq = 12'h100;
    i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      driveAddi(seq);
      i_valid = 1'b1;
      @(negedge i_clk);
      checkOutput("stream_valid", 32'(o_valid), 32'd1);
      checkOutput("stream_inst",  o_inst, iWord(seq));
      checkOutput("stream_ready", 32'(o_ready), 32'd1);
      seq = seq + 12'd1;
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    checkOutput("stream_empty", 32'(o_valid), 32'd0);
    i_ready = 1'b0;

    // Mid-stream reset with two entries buffered.
    for (int c = 0; c < 2; c++) begin
      driveAddi(12'h200 + 12'(c));
      i_valid = 1'b1;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    checkOutput("mrst_pre_full", 32'(o_ready), 32'd0);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("mrst_valid", 32'(o_valid), 32'd0);
    checkOutput("mrst_ready", 32'(o_ready), 32'd1);
    checkOutput("mrst_inst",  o_inst,       32'd0);
`ifdef INST_ENCODER_ERR_CNT_EN
    checkOutput("mrst_errcnt", 32'(o_err_cnt), 32'd0);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    driveAddi(12'h055);
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    checkOutput("post_valid", 32'(o_valid), 32'd1);
    checkOutput("post_inst",  o_inst, iWord(12'h055));
    i_ready = 1'b1;
    @(negedge i_clk);
    checkOutput("post_alone", 32'(o_valid), 32'd0);
    i_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
